// File: rtl/intraloop_pkg.sv
// rtl/intraloop_pkg.sv - shared types and constants for the intra-loop block scheduler
package intraloop_pkg;

  localparam int BLKIDX_W        = 5;
  localparam int DEF_LUMA_BLKS   = 16;
  localparam int DEF_CHROMA_BLKS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LUMA_ISSUE,
    ST_LUMA_WAIT,
    ST_CHROMA_ISSUE,
    ST_DRAIN,
    ST_MB_END
  } state_e;

endpackage

// File: rtl/intraloop_inflight.sv
// rtl/intraloop_inflight.sv - saturating up/down count of outstanding blocks
// A decrement at zero leaves the count alone and latches underflow until reset.
module intraloop_inflight (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] count,
  output logic [3:0] count_next,
  output logic       underflow
);

  logic [3:0] count_q, count_d;
  logic       uf_q, uf_d;

  always_comb begin
    count_d = count_q;
    uf_d    = uf_q;
    if (inc && !dec) begin
      if (count_q != 4'hF) count_d = count_q + 4'd1;
    end else if (dec && !inc) begin
      if (count_q == 4'd0) uf_d = 1'b1;
      else                 count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 4'd0;
      uf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      uf_q    <= uf_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;
  assign underflow  = uf_q;

endmodule

// File: rtl/intraloop_sched.sv
// rtl/intraloop_sched.sv - issues luma blocks one at a time, then chroma blocks pipelined
// INTRALOOP_SCHED_STATS_EN adds the stall_cycles output.
module intraloop_sched
  import intraloop_pkg::*;
#(
  parameter int MBNUM_W      = 13,
  parameter int LUMA_BLKS    = DEF_LUMA_BLKS,
  parameter int CHROMA_BLKS  = DEF_CHROMA_BLKS,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [MBNUM_W-1:0]  frame_mbs,
  output logic                issue_valid,
  input  logic                issue_ready,
  output logic [MBNUM_W-1:0]  issue_mbnumber,
  output logic [BLKIDX_W-1:0] issue_blkidx,
  output logic                issue_chroma,
  input  logic                recon_done,
  output logic [3:0]          inflight,
  output logic                mb_done,
  output logic                frame_done,
  output logic                busy,
`ifdef INTRALOOP_SCHED_STATS_EN
  output logic [31:0]         stall_cycles,
`endif
  output logic                err
);

  localparam logic [BLKIDX_W-1:0] LUMA_LAST   = BLKIDX_W'(LUMA_BLKS - 1);
  localparam logic [BLKIDX_W-1:0] CHROMA_LAST = BLKIDX_W'(CHROMA_BLKS - 1);
  localparam logic [BLKIDX_W-1:0] BLK_ONE     = BLKIDX_W'(1);
  localparam logic [MBNUM_W-1:0]  MB_ONE      = MBNUM_W'(1);
  localparam logic [3:0]          MAX_CNT     = 4'(MAX_INFLIGHT);

  state_e              state_q, state_d;
  logic [MBNUM_W-1:0]  frame_mbs_q, frame_mbs_d;
  logic [MBNUM_W-1:0]  mbnum_q, mbnum_d;
  logic [BLKIDX_W-1:0] blkidx_q, blkidx_d;
  logic                chroma_q, chroma_d;
  logic                valid_q, valid_d;
  logic                mb_done_q, mb_done_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;
  logic                handshake, last_mb;
  logic [3:0]          inflight_nxt;

  assign handshake = valid_q & issue_ready;
  assign last_mb   = (mbnum_q == frame_mbs_q - MB_ONE);

  intraloop_inflight u_inflight (
    .clk        (clk),
    .rst        (reset),
    .inc        (handshake),
    .dec        (recon_done),
    .count      (inflight),
    .count_next (inflight_nxt),
    .underflow  (err)
  );

  always_comb begin
    state_d      = state_q;
    frame_mbs_d  = frame_mbs_q;
    mbnum_d      = mbnum_q;
    blkidx_d     = blkidx_q;
    chroma_d     = chroma_q;
    valid_d      = valid_q;
    mb_done_d    = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          frame_mbs_d = frame_mbs;
          mbnum_d     = '0;
          blkidx_d    = '0;
          chroma_d    = 1'b0;
          if (frame_mbs == '0) frame_done_d = 1'b1;
          else                 state_d      = ST_LUMA_ISSUE;
        end
      end
      ST_LUMA_ISSUE: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (issue_ready) begin
          valid_d = 1'b0;
          state_d = ST_LUMA_WAIT;
        end
      end
      ST_LUMA_WAIT: begin
        if (recon_done) begin
          if (blkidx_q == LUMA_LAST) begin
            blkidx_d = '0;
            chroma_d = 1'b1;
            state_d  = ST_CHROMA_ISSUE;
          end else begin
            blkidx_d = blkidx_q + BLK_ONE;
            state_d  = ST_LUMA_ISSUE;
          end
        end
      end
      ST_CHROMA_ISSUE: begin
        // Valid is registered, so gate it on next cycle's count to avoid overshooting the window.
        if (handshake) begin
          if (blkidx_q == CHROMA_LAST) begin
            valid_d = 1'b0;
            state_d = ST_DRAIN;
          end else begin
            blkidx_d = blkidx_q + BLK_ONE;
            valid_d  = (inflight_nxt < MAX_CNT);
          end
        end else if (!valid_q) begin
          valid_d = (inflight_nxt < MAX_CNT);
        end
      end
      ST_DRAIN: begin
        if (inflight == 4'd0) begin
          mb_done_d    = 1'b1;
          frame_done_d = last_mb;
          state_d      = ST_MB_END;
        end
      end
      ST_MB_END: begin
        blkidx_d = '0;
        chroma_d = 1'b0;
        if (last_mb) begin
          mbnum_d = '0;
          state_d = ST_IDLE;
        end else begin
          mbnum_d = mbnum_q + MB_ONE;
          state_d = ST_LUMA_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      frame_mbs_q  <= '0;
      mbnum_q      <= '0;
      blkidx_q     <= '0;
      chroma_q     <= 1'b0;
      valid_q      <= 1'b0;
      mb_done_q    <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_mbs_q  <= frame_mbs_d;
      mbnum_q      <= mbnum_d;
      blkidx_q     <= blkidx_d;
      chroma_q     <= chroma_d;
      valid_q      <= valid_d;
      mb_done_q    <= mb_done_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign issue_valid    = valid_q;
  assign issue_mbnumber = mbnum_q;
  assign issue_blkidx   = blkidx_q;
  assign issue_chroma   = chroma_q;
  assign mb_done        = mb_done_q;
  assign frame_done     = frame_done_q;
  assign busy           = busy_q;

`ifdef INTRALOOP_SCHED_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_IDLE && state_d != ST_IDLE) stall_d = '0;
    else if (valid_q && !issue_ready && stall_q != '1) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_intraloop_sched.sv
// tb/tb_intraloop_sched.sv - directed self-checking bench for intraloop_sched
module tb_intraloop_sched;

  localparam int MBNUM_W = 13;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic [MBNUM_W-1:0] frame_mbs = '0;
  logic               issue_ready = 1'b0;
  logic               man_recon = 1'b0;
  logic               chroma_auto = 1'b1;
  logic               recon_done;
  logic               issue_valid, issue_chroma, mb_done, frame_done, busy, err;
  logic [MBNUM_W-1:0] issue_mbnumber;
  logic [4:0]         issue_blkidx;
  logic [3:0]         inflight;
`ifdef INTRALOOP_SCHED_STATS_EN
  logic [31:0]        stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  int luma_hs = 0, chroma_hs = 0, valid_cyc = 0, mb_cnt = 0, fd_cnt = 0, both_cnt = 0;
  logic [MBNUM_W-1:0] mb_seq [0:15];
  logic [3:0] hs_pipe = 4'd0;
  int base_l, base_c, base_v, base_mb, base_fd, base_both;

  assign recon_done = man_recon | hs_pipe[1];

  always #5 clk = ~clk;

  intraloop_sched dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .frame_mbs      (frame_mbs),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_mbnumber (issue_mbnumber),
    .issue_blkidx   (issue_blkidx),
    .issue_chroma   (issue_chroma),
    .recon_done     (recon_done),
    .inflight       (inflight),
    .mb_done        (mb_done),
    .frame_done     (frame_done),
    .busy           (busy),
`ifdef INTRALOOP_SCHED_STATS_EN
    .stall_cycles   (stall_cycles),
`endif
    .err            (err)
  );

  // Observes pre-edge values; the recon responder answers each handshake two cycles later.
  always @(posedge clk) begin
    if (issue_valid && issue_ready) begin
      if (issue_chroma) chroma_hs <= chroma_hs + 1;
      else              luma_hs   <= luma_hs + 1;
    end
    if (issue_valid) valid_cyc <= valid_cyc + 1;
    if (mb_done) begin
      if (mb_cnt < 16) mb_seq[mb_cnt] <= issue_mbnumber;
      mb_cnt <= mb_cnt + 1;
    end
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (mb_done && frame_done) both_cnt <= both_cnt + 1;
    hs_pipe <= {hs_pipe[2:0], issue_valid && issue_ready && (!issue_chroma || chroma_auto)};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic snap();
    base_l = luma_hs; base_c = chroma_hs; base_v = valid_cyc;
    base_mb = mb_cnt; base_fd = fd_cnt; base_both = both_cnt;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic wait_fd(input string tag, input int bound);
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    check(tag, 32'(frame_done), 1);
  endtask

  initial begin
    int bad, n;
    #1;
    check("rst_valid", 32'(issue_valid), 0);
    check("rst_mbnum", 32'(issue_mbnumber), 0);
    check("rst_blkidx", 32'(issue_blkidx), 0);
    check("rst_chroma", 32'(issue_chroma), 0);
    check("rst_inflight", 32'(inflight), 0);
    check("rst_pulses", 32'({mb_done, frame_done}), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    step();
    reset = 1'b0;
    step();

    // One macroblock, always ready, all recons at fixed latency
    frame_mbs = 13'd1; issue_ready = 1'b1; chroma_auto = 1'b1;
    snap();
    enable = 1'b1; step(); enable = 1'b0;
    check("t1_busy", 32'(busy), 1);
    wait_fd("t1_frame_done", 600);
    check("t1_mbdone_with_fd", 32'(mb_done), 1);
    step(); step();
    check("t1_luma_issues", luma_hs - base_l, 16);
    check("t1_chroma_issues", chroma_hs - base_c, 8);
    check("t1_mb_done_cnt", mb_cnt - base_mb, 1);
    check("t1_fd_cnt", fd_cnt - base_fd, 1);
    check("t1_same_cycle", both_cnt - base_both, 1);
    check("t1_err", 32'(err), 0);
    check("t1_idle", 32'({busy, inflight}), 0);

    // Backpressure on luma block 3
    do_reset();
    frame_mbs = 13'd1; issue_ready = 1'b1;
    snap();
    enable = 1'b1; step(); enable = 1'b0;
    n = 0;
    while (!(issue_blkidx == 5'd3 && !issue_valid && !issue_chroma) && n < 200) begin
      step();
      n++;
    end
    check("t2_reach_blk3", 32'(n < 200), 1);
    issue_ready = 1'b0;
    bad = 0;
    repeat (6) begin
      step();
      if (!(issue_valid && issue_blkidx == 5'd3 && !issue_chroma)) bad++;
    end
    check("t2_blk3_stable", bad, 0);
    check("t2_no_advance", luma_hs - base_l, 3);
    issue_ready = 1'b1;
    wait_fd("t2_frame_done", 600);
    step(); step();
    check("t2_luma_issues", luma_hs - base_l, 16);
    check("t2_chroma_issues", chroma_hs - base_c, 8);
`ifdef INTRALOOP_SCHED_STATS_EN
    check("t2_stall_cycles", stall_cycles, 5);
`endif

    // Chroma window fills with recons withheld
    do_reset();
    frame_mbs = 13'd1; issue_ready = 1'b1; chroma_auto = 1'b0;
    snap();
    enable = 1'b1; step(); enable = 1'b0;
    n = 0;
    while (chroma_hs - base_c < 4 && n < 300) begin
      step();
      n++;
    end
    bad = 0;
    repeat (6) begin
      step();
      if (issue_valid) bad++;
    end
    check("t3_valid_low", bad, 0);
    check("t3_chroma_issues", chroma_hs - base_c, 4);
    check("t3_inflight_full", 32'(inflight), 4);
    issue_ready = 1'b0; man_recon = 1'b1;
    step(); step();
    check("t3_inflight_two", 32'(inflight), 2);
    issue_ready = 1'b1;
    step();
    man_recon = 1'b0; issue_ready = 1'b0;
    check("t3_same_cycle_inflight", 32'(inflight), 2);
    check("t3_chroma_issues5", chroma_hs - base_c, 5);
    check("t3_blkidx5", 32'({issue_chroma, issue_blkidx}), 32'h25);

    // Reset mid-chroma, then a stray recon
    reset = 1'b1;
    #1;
    check("t3_rst_outputs", 32'({issue_valid, issue_chroma, mb_done, frame_done, busy, err}), 0);
    check("t3_rst_blk_mb", 32'({issue_mbnumber, issue_blkidx}), 0);
    check("t3_rst_inflight", 32'(inflight), 0);
    step();
    reset = 1'b0;
    step();
    man_recon = 1'b1; step(); man_recon = 1'b0; step();
    check("t3_stray_err", 32'(err), 1);
    check("t3_stray_inflight", 32'(inflight), 0);

    // Empty frame
    do_reset();
    chroma_auto = 1'b1; issue_ready = 1'b1; frame_mbs = 13'd0;
    snap();
    enable = 1'b1; step(); enable = 1'b0;
    check("t4_fd_pulse", 32'(frame_done), 1);
    check("t4_busy", 32'(busy), 0);
    step();
    check("t4_fd_low", 32'(frame_done), 0);
    step();
    check("t4_fd_cnt", fd_cnt - base_fd, 1);
    check("t4_no_valid", valid_cyc - base_v, 0);

    // Three macroblocks, enable held high through the frame
    frame_mbs = 13'd3;
    snap();
    enable = 1'b1;
    wait_fd("t5_frame_done", 2000);
    enable = 1'b0;
    check("t5_mbnum_last", 32'(issue_mbnumber), 2);
    step(); step(); step();
    check("t5_mb_cnt", mb_cnt - base_mb, 3);
    check("t5_mb0", 32'(mb_seq[base_mb]), 0);
    check("t5_mb1", 32'(mb_seq[base_mb + 1]), 1);
    check("t5_mb2", 32'(mb_seq[base_mb + 2]), 2);
    check("t5_wrap", 32'(issue_mbnumber), 0);
    check("t5_luma", luma_hs - base_l, 48);
    check("t5_fd_cnt", fd_cnt - base_fd, 1);
    check("t5_idle", 32'({busy, err}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intraloop_sched.md
INTRALOOP_SCHED -- requirements
Module: intraloop_sched

Interface
REQ-001 SHALL have parameter MBNUM_W, default 13, width of macroblock number.
REQ-002 SHALL have parameter LUMA_BLKS, default 16, luma 4x4 blocks per macroblock.
REQ-003 SHALL have parameter CHROMA_BLKS, default 8, chroma 4x4 blocks per macroblock (Cb then Cr, half each).
REQ-004 SHALL have parameter MAX_INFLIGHT, default 4, maximum outstanding chroma blocks; range 1..15.
REQ-005 SHALL have ports: clk in 1, rising-edge clock; reset in 1, asynchronous active-high.
REQ-006 SHALL have ports: enable in 1, start frame; frame_mbs in MBNUM_W, macroblocks in frame.
REQ-007 SHALL have ports: issue_valid out 1; issue_ready in 1; issue_mbnumber out MBNUM_W; issue_blkidx out 5; issue_chroma out 1.
REQ-008 SHALL have ports: recon_done in 1, one pulse per reconstructed block; inflight out 4.
REQ-009 SHALL have ports: mb_done out 1, pulse; frame_done out 1, pulse; busy out 1; err out 1, sticky.

Function
REQ-010 SHALL implement states IDLE, LUMA_ISSUE, LUMA_WAIT, CHROMA_ISSUE, DRAIN, MB_END.
REQ-011 IDLE: enable=1 moves to LUMA_ISSUE with mbnumber=0, blkidx=0; frame_mbs sampled here, held for the frame.
REQ-012 Issue handshake completes when issue_valid and issue_ready are both 1; issue_* outputs are held stable while issue_valid=1 and issue_ready=0.
REQ-013 Luma: exactly one block in flight; after handshake go to LUMA_WAIT; recon_done returns to LUMA_ISSUE with blkidx+1, or to CHROMA_ISSUE after blkidx LUMA_BLKS-1.
REQ-014 Chroma: issue_chroma=1, blkidx counts 0..CHROMA_BLKS-1; issue_valid deasserted while inflight=MAX_INFLIGHT; after last handshake go to DRAIN.
REQ-015 DRAIN waits for inflight=0, then MB_END; MB_END asserts mb_done one cycle, increments mbnumber, returns to LUMA_ISSUE.
REQ-016 After macroblock frame_mbs-1: frame_done one cycle (same cycle as its mb_done), mbnumber wraps to 0, state IDLE.
REQ-017 inflight: +1 on handshake, -1 on recon_done, unchanged when both in same cycle.
REQ-018 recon_done with inflight=0 (and no same-cycle handshake) SHALL be ignored for counting and set err until reset.
REQ-019 frame_mbs=0: frame_done pulses the cycle after enable sampled; no issues made.
REQ-020 enable is ignored outside IDLE; deassertion mid-frame does not stop the frame.
REQ-021 busy=1 in every state except IDLE.
REQ-022 Issue latency: issue_valid asserts the cycle after entering LUMA_ISSUE/CHROMA_ISSUE.

Reset
REQ-023 reset SHALL asynchronously force IDLE, issue_valid=0, issue_mbnumber=0, issue_blkidx=0, issue_chroma=0, inflight=0, mb_done=0, frame_done=0, busy=0, err=0.
REQ-024 Reset mid-frame SHALL abandon outstanding blocks; subsequent recon_done with inflight=0 sets err.

Configuration
REQ-025 Macro INTRALOOP_SCHED_STATS_EN: when defined, adds output stall_cycles (32 bits), counting cycles with issue_valid=1 and issue_ready=0, cleared on reset and on IDLE exit, saturating at all-ones; when undefined the port and counter are absent.

Structure
REQ-026 Package intraloop_pkg SHALL hold the state enum, BLKIDX_W=5 and default LUMA_BLKS/CHROMA_BLKS constants.
REQ-027 One sub-module intraloop_inflight (saturating up/down counter with underflow flag) SHALL implement REQ-017/018.

Verification
REQ-028 frame_mbs=1, issue_ready=1, recon_done 2 cycles after each luma issue, chroma recon_done same latency -> 16 luma + 8 chroma issues, one mb_done, one frame_done, err=0.
REQ-029 issue_ready held 0 for 5 cycles on luma blk 3 -> issue_blkidx=3 stable, no advance; STATS build stall_cycles=5.
REQ-030 Chroma with recon_done withheld -> exactly 4 chroma handshakes, inflight=4, issue_valid=0 until first recon_done.
REQ-031 Handshake and recon_done in same cycle at inflight=2 -> inflight stays 2.
REQ-032 frame_mbs=0 -> frame_done one cycle after enable, no issue_valid; frame_mbs=3 -> mbnumber 0,1,2 then wraps to 0.
REQ-033 Reset asserted at chroma blk 5, then stray recon_done -> all outputs at reset values, err=1 after the stray pulse.
